// File: rtl/rcv_control.sv
// Receive control for the UART receiver: start detection, timer enable, stop-bit check and output buffer.
// Optional start-bit glitch filter is enabled by defining START_GLITCH_FILTER_EN.
module rcv_control #(
  parameter int DATA_BITS = 8,
  parameter int HALF_BIT  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 packet_done,
  input  logic [DATA_BITS-1:0] packet_data,
  input  logic                 stop_bit,
  input  logic                 data_read,
  output logic                 enable_timer,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);

`ifdef START_GLITCH_FILTER_EN
  typedef enum logic [2:0] {
    IDLE, FILTER, START, RECEIVE, STOPCHK, LOAD
  } state_t;
  localparam int CNT_W = $clog2(HALF_BIT + 1);
  logic [CNT_W-1:0] filt_cnt_reg;
`else
  typedef enum logic [2:0] {
    IDLE, START, RECEIVE, STOPCHK, LOAD
  } state_t;
`endif

  state_t state_reg, state_next;

  logic                 s1_reg, s2_reg, s3_reg;
  logic                 start_det;
  logic                 enable_timer_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 data_ready_reg;
  logic                 overrun_error_reg;
  logic                 framing_error_reg;

  // Two-flop synchroniser plus edge register; falling edge marks a start bit.
  assign start_det = s3_reg & ~s2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 1'b1;
      s2_reg <= 1'b1;
      s3_reg <= 1'b1;
    end else begin
      s1_reg <= serial_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      enable_timer_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      enable_timer_reg <= (state_next == RECEIVE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_det) begin
`ifdef START_GLITCH_FILTER_EN
          state_next = FILTER;
`else
          state_next = START;
`endif
        end
      end
`ifdef START_GLITCH_FILTER_EN
      // Line going back high before the half-bit wait is a glitch, not a start bit.
      FILTER: begin
        if (s2_reg)
          state_next = IDLE;
        else if (filt_cnt_reg == CNT_W'(HALF_BIT - 1))
          state_next = START;
      end
`endif
      START:   state_next = RECEIVE;
      RECEIVE: if (packet_done) state_next = STOPCHK;
      STOPCHK: state_next = stop_bit ? LOAD : IDLE;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef START_GLITCH_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst || state_reg != FILTER)
      filt_cnt_reg <= '0;
    else
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
  end
`endif

  // A load in the same clock as data_read overrides the clear of data_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_reg       <= '1;
      data_ready_reg    <= 1'b0;
      overrun_error_reg <= 1'b0;
      framing_error_reg <= 1'b0;
    end else begin
      if (state_reg == START)
        framing_error_reg <= 1'b0;
      if (state_reg == STOPCHK && !stop_bit)
        framing_error_reg <= 1'b1;
      if (data_read) begin
        data_ready_reg    <= 1'b0;
        overrun_error_reg <= 1'b0;
      end
      if (state_reg == LOAD) begin
        rx_data_reg    <= packet_data;
        data_ready_reg <= 1'b1;
        if (data_ready_reg && !data_read)
          overrun_error_reg <= 1'b1;
      end
    end
  end

  assign enable_timer  = enable_timer_reg;
  assign rx_data       = rx_data_reg;
  assign data_ready    = data_ready_reg;
  assign overrun_error = overrun_error_reg;
  assign framing_error = framing_error_reg;

endmodule
